// File: rtl/spi_enc_dec_slave.sv
// spi_enc_dec_slave: serial responder that shifts in a message word and an expanded key, starts the AES core, then shifts the result back
// Ports:
//   in_clk       single clock, rising edge
//   rst          asynchronous active-high reset
//   cs_enc_dec   select; each high cycle is one bit slot
//   Mosi         serial input, message then key, MSB first
//   Miso         serial result, MSB first
//   core_msg     received message block to the core
//   core_key     received expanded key to the core
//   core_start   one-cycle start pulse to the core
//   core_done    core result valid, sampled only while waiting
//   core_result  core output block
//   busy         high whenever not idle
//   frame_err    one-cycle pulse after a truncated receive frame
// Optional: define SPI_ENC_DEC_LOOPBACK_EN to bypass the core and echo the received message.
module spi_enc_dec_slave #(
  parameter int NK = 8,
  parameter int NB = 4,
  parameter int NR = 14,
  localparam int MSG_W = 32*NB,
  localparam int KEY_W = 32*NB*(NR+1),
  localparam int TOTAL = MSG_W + KEY_W,
  localparam int CW = $clog2(TOTAL+1)
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             cs_enc_dec,
  input  logic             Mosi,
  output logic             Miso,
  output logic [MSG_W-1:0] core_msg,
  output logic [KEY_W-1:0] core_key,
  output logic             core_start,
  input  logic             core_done,
  input  logic [MSG_W-1:0] core_result,
  output logic             busy,
  output logic             frame_err
);
  if (NK < 1) begin : g_nk
    $error("NK must be positive");
  end
  typedef enum logic [2:0] {IDLE, RX, START, WAIT, TX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The newest bit arrives on Mosi, so only TOTAL-1 bits need storing.
  logic [TOTAL-2:0] rx_q, rx_d;
  logic [TOTAL-1:0] rx_full;
  // Zero-filled left shift: the register empties as bits go out, so its MSB is Miso and reads 0 when idle.
  logic [MSG_W-1:0] tx_q, tx_d, msg_q, msg_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic ferr_q, ferr_d;
  assign rx_full = {rx_q, Mosi};
  assign Miso = tx_q[MSG_W-1];
  assign core_msg = msg_q;
  assign core_key = key_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
`ifdef SPI_ENC_DEC_LOOPBACK_EN
  assign core_start = 1'b0;
`else
  assign core_start = state_q == START;
`endif
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      msg_q <= '0;
      key_q <= '0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      msg_q <= msg_d;
      key_q <= key_d;
      ferr_q <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    msg_d = msg_q;
    key_d = key_q;
    ferr_d = 1'b0;
    case (state_q)
      IDLE: if (cs_enc_dec) begin
        rx_d = rx_full[TOTAL-2:0];
        cnt_d = CW'(1);
        state_d = RX;
      end
      RX: if (cs_enc_dec) begin
        rx_d = rx_full[TOTAL-2:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TOTAL-1)) begin
          msg_d = rx_full[TOTAL-1:KEY_W];
          key_d = rx_full[KEY_W-1:0];
          cnt_d = '0;
          state_d = START;
        end
      end else begin
        ferr_d = 1'b1;
        cnt_d = '0;
        rx_d = '0;
        state_d = IDLE;
      end
`ifdef SPI_ENC_DEC_LOOPBACK_EN
      START: begin
        tx_d = msg_q;
        cnt_d = '0;
        state_d = TX;
      end
`else
      START: state_d = WAIT;
      WAIT: if (core_done) begin
        tx_d = core_result;
        cnt_d = '0;
        state_d = TX;
      end
`endif
      TX: if (cs_enc_dec) begin
        tx_d = {tx_q[MSG_W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MSG_W-1)) begin
          tx_d = '0;
          cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_enc_dec_slave.sv
// tb_spi_enc_dec_slave: randomized self-checking bench for spi_enc_dec_slave with NB=1, NR=0
module tb_spi_enc_dec_slave;
`ifdef SPI_ENC_DEC_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  logic in_clk = 0, rst = 1, cs_enc_dec = 0, Mosi = 0, core_done = 0;
  logic [31:0] core_result = '0;
  logic Miso, core_start, busy, frame_err;
  logic [31:0] core_msg, core_key;
  logic [31:0] last_msg = '0, last_key = '0;
  int n_cmp = 0, n_bad = 0;
  always #5 in_clk = ~in_clk;
  spi_enc_dec_slave #(.NK(8), .NB(1), .NR(0)) dut (
    .in_clk(in_clk), .rst(rst), .cs_enc_dec(cs_enc_dec), .Mosi(Mosi), .Miso(Miso),
    .core_msg(core_msg), .core_key(core_key), .core_start(core_start), .core_done(core_done),
    .core_result(core_result), .busy(busy), .frame_err(frame_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask
  task automatic send(input logic [63:0] frame, input int nbits);
    logic early;
    early = 0;
    for (int i = 0; i < nbits; i++) begin
      cs_enc_dec = 1;
      Mosi = frame[63-i];
      core_done = 1'($urandom);
      core_result = $urandom;
      tick();
      if (i < nbits-1) early |= core_start | frame_err | ~busy;
    end
    cs_enc_dec = 0;
    core_done = 0;
    chk("rx_quiet", 64'(early), 0);
  endtask
  task automatic recv(input int nslots, input bit fgap, output logic [31:0] got);
    logic frz, bsy, prev;
    frz = 0;
    bsy = 0;
    got = '0;
    for (int k = 0; k < nslots; k++) begin
      int g;
      g = fgap ? (k == 16 ? 5 : 0) : ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 5)) : 0);
      cs_enc_dec = 0;
      repeat (g) begin
        prev = Miso;
        tick();
        frz |= (Miso !== prev) | ~busy;
      end
      cs_enc_dec = 1;
      Mosi = 1'($urandom);
      core_done = 1'($urandom);
      core_result = $urandom;
      got[31-k] = Miso;
      bsy |= ~busy;
      tick();
    end
    cs_enc_dec = 0;
    core_done = 0;
    chk("tx_pause_hold", 64'(frz), 0);
    chk("tx_busy", 64'(bsy), 0);
  endtask
  task automatic to_tx(input logic [31:0] m, input logic [31:0] r, input int dly, output logic [31:0] exp);
    logic bad;
    bad = 0;
    tick();
    if (LB) exp = m;
    else begin
      chk("start_len", 64'(core_start), 0);
      repeat (dly) begin
        cs_enc_dec = 1'($urandom);
        Mosi = 1'($urandom);
        tick();
        bad |= core_start | ~busy | (core_msg !== m);
      end
      cs_enc_dec = 1'($urandom);
      core_done = 1;
      core_result = r;
      tick();
      core_done = 0;
      cs_enc_dec = 0;
      chk("wait_hold", 64'(bad), 0);
      exp = r;
    end
  endtask
  task automatic txn(input logic [31:0] m, input logic [31:0] k, input logic [31:0] r, input int dly, input bit fgap);
    logic [31:0] got, exp;
    send({m, k}, 64);
    chk("core_start", 64'(core_start), LB ? 0 : 1);
    chk("core_msg", 64'(core_msg), 64'(m));
    chk("core_key", 64'(core_key), 64'(k));
    last_msg = m;
    last_key = k;
    to_tx(m, r, dly, exp);
    chk("miso_first", 64'(Miso), 64'(exp[31]));
    recv(32, fgap, got);
    chk("tx_word", 64'(got), 64'(exp));
    chk("idle_after_tx", {busy, Miso}, 0);
  endtask
  task automatic abort(input int n);
    send({$urandom, $urandom}, n);
    tick();
    chk("frame_err", {frame_err, busy}, 2'b10);
    chk("abort_core", {core_msg, core_key}, {last_msg, last_key});
    tick();
    chk("frame_err_len", 64'(frame_err), 0);
  endtask
  task automatic rst_now(input string tag);
    rst = 1;
    #1;
    chk(tag, {Miso, busy, frame_err, core_start}, 0);
    chk({tag, "_core"}, {core_msg, core_key}, 0);
    tick();
    rst = 0;
    last_msg = '0;
    last_key = '0;
  endtask
  initial begin
    logic [31:0] got, exp;
    #1;
    chk("rst_ctl", {Miso, busy, frame_err, core_start}, 0);
    chk("rst_core", {core_msg, core_key}, 0);
    repeat (2) tick();
    rst = 0;
    txn(32'hDEADBEEF, 32'h01234567, 32'hA5A5F00F, 10, 1);
    abort(40);
    txn($urandom, $urandom, $urandom, 3, 0);
    for (int i = 0; i < 6; i++) txn($urandom, $urandom, $urandom, $urandom_range(0, 12), 0);
    for (int i = 0; i < 4; i++) abort($urandom_range(1, 63));
    txn($urandom, $urandom, $urandom, 0, 0);
    send({$urandom, $urandom}, 64);
    if (!LB) begin
      repeat (3) tick();
      rst_now("rst_wait");
    end
    send({$urandom, $urandom}, 64);
    to_tx(core_msg, 32'hFFFFFFFF, 2, exp);
    recv(10, 0, got);
    chk("miso_bit10", 64'(Miso), 64'(exp[21]));
    rst_now("rst_tx");
    txn($urandom, $urandom, $urandom, 4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
